// File: rtl/cpu_pkg.sv
// Shared fetch-path defaults and the {pc, inst} bundle
// passed from fetch into decode.
package cpu_pkg;

  localparam int DEF_PC_W    = 16;
  localparam int DEF_INST_W  = 16;
  localparam int DEF_ROM_AW  = 12;
  localparam int DEF_PC_STEP = 2;
  localparam int DEF_DEPTH   = 4;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x W register array,
// one write port, one combinational read port, no reset.
module fetch_queue_mem #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          write_en,
  input  logic [AW-1:0] write_addr,
  input  logic [W-1:0]  write_data,
  input  logic [AW-1:0] read_addr,
  output logic [W-1:0]  read_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: generates PCs, reads the ROM and
// buffers {pc, inst} for decode; redirects flush everything.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int PC_W    = DEF_PC_W,
  parameter  int INST_W  = DEF_INST_W,
  parameter  int ROM_AW  = DEF_ROM_AW,
  parameter  int PC_STEP = DEF_PC_STEP,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [PW:0]       level
);

  localparam int EW = PC_W + INST_W;

  logic [PC_W-1:0] fetch_pc;
  logic [PW:0]     head;
  logic [PW:0]     tail;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic [EW-1:0]   head_entry;

  // Extra wrap bit distinguishes full from empty.
  assign empty = (head == tail);
  assign full  = (head[PW] != tail[PW]) &&
                 (head[PW-1:0] == tail[PW-1:0]);
  assign level = tail - head;

  assign out_valid = ~empty;
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & (~full | pop);

  assign rom_addr = fetch_pc[ROM_AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (push) begin
        tail     <= tail + 1'b1;
        fetch_pc <= fetch_pc + PC_W'(PC_STEP);
      end
      if (pop) head <= head + 1'b1;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clock      (clock),
    .write_en   (push),
    .write_addr (tail[PW-1:0]),
    .write_data ({fetch_pc, rom_data}),
    .read_addr  (head[PW-1:0]),
    .read_data  (head_entry)
  );

  assign out_pc   = head_entry[EW-1 -: PC_W];
  assign out_inst = head_entry[INST_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push
// expected pops; a negedge monitor pops and compares.
module tb_fetch_queue;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic [2:0]  level;

  int checks = 0;
  int passes = 0;
  fetch_entry_t exp_q[$];

  always #5 clock = ~clock;

  // ROM[i] = i + 1 for word index i = addr / 2.
  assign rom_data = {5'b0, rom_addr[11:1]} + 16'd1;

  fetch_queue dut (
    .clock           (clock),
    .reset           (reset),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .level           (level)
  );

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_entry(int pc, int inst);
    fetch_entry_t e;
    e.pc   = 16'(pc);
    e.inst = 16'(inst);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pop: got pc 0x%0h, expected none",
                 out_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        check("pop_pc", int'(out_pc), int'(e.pc));
        check("pop_inst", int'(out_inst), int'(e.inst));
      end
    end
  end

  initial begin
    // Reset state, then stream with out_ready held high.
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    for (int i = 0; i < 7; i++) expect_entry(2 * i, i + 1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_valid", int'(out_valid), 1);
    end
    out_ready = 1'b0;
    tick();
    check("stream_drained", exp_q.size(), 0);

    // Stall fills the queue; release drains in order while refilling.
    do_reset();
    repeat (10) tick();
    check("stall_level", int'(level), 4);
    check("stall_rom_addr", int'(rom_addr), 8);
    check("stall_head_pc", int'(out_pc), 0);
    check("stall_head_inst", int'(out_inst), 1);
    for (int i = 0; i < 5; i++) expect_entry(2 * i, i + 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("full_pushpop_level", int'(level), 4);
    end
    out_ready = 1'b0;
    tick();
    check("stall_drained", exp_q.size(), 0);

    // Single-cycle redirect with three entries queued.
    do_reset();
    repeat (3) tick();
    check("pre_redir_level", int'(level), 3);
    redirect_valid = 1'b1;
    redirect_target = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", int'(out_valid), 0);
    check("redir_level", int'(level), 0);
    check("redir_rom_addr", int'(rom_addr), 'h40);
    expect_entry('h40, 'h21);
    expect_entry('h42, 'h22);
    expect_entry('h44, 'h23);
    out_ready = 1'b1;
    tick();
    check("redir_head_pc", int'(out_pc), 'h40);
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    check("redir_drained", exp_q.size(), 0);

    // Back-to-back redirects: last target wins.
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      redirect_target = 16'(16 * i);
      tick();
      check("b2b_level", int'(level), 0);
      check("b2b_valid", int'(out_valid), 0);
    end
    redirect_valid = 1'b0;
    expect_entry('h30, 'h19);
    expect_entry('h32, 'h1a);
    expect_entry('h34, 'h1b);
    out_ready = 1'b1;
    tick();
    check("b2b_head_pc", int'(out_pc), 'h30);
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    check("b2b_drained", exp_q.size(), 0);

    // Reset overrides a simultaneous redirect mid-operation.
    do_reset();
    repeat (3) tick();
    check("pre_rst_level", int'(level), 3);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 16'h0050;
    tick();
    check("midrst_level", int'(level), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_rom_addr", int'(rom_addr), 0);
    reset = 1'b0;
    redirect_valid = 1'b0;
    tick();
    check("post_rst_head_pc", int'(out_pc), 0);
    check("post_rst_level", int'(level), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
